// File: rtl/host_mem_responder.sv
// host_mem_responder
//   Memory-side responder for the scratchpad host interface. Services one
//   read or write at a time out of a word-addressed backing RAM and answers
//   each access with a one-cycle ready pulse after a fixed latency.
//
//   Optional feature macro: RESP_JITTER_EN
//     defined   : a 16-bit LFSR (seed 16'hACE1) adds 0..3 extra wait cycles
//                 to every access; ordering and data are unchanged.
//     undefined : latency is exactly RD_LAT+1 (reads) / WR_LAT+1 (writes).
//
//   Ports
//     clk              clock
//     reset            asynchronous, active-high
//     i_read_enable    read request
//     i_read_addr      byte address of read (64)
//     i_finish_read    initiator stream ack, counted only
//     i_write_enable   write request
//     i_write_addr     byte address of write (64)
//     i_write_data     write payload (DATA_WID)
//     i_finish_write   initiator stream ack, counted only
//     o_read_ready     1 for one cycle when o_read_data is valid (64)
//     o_read_data      read result, held until the next read_ready
//     o_write_ready    1 for one cycle when the write has been committed (64)
//     o_busy           access in flight or a write is pending
//     o_oob_count      saturating count of out-of-range accesses
module host_mem_responder #(
  parameter int                  ADDR_WID = 16,
  parameter int                  DATA_WID = 32,
  parameter logic [63:0]         BASE     = 64'h0,
  parameter int                  RD_LAT   = 4,
  parameter int                  WR_LAT   = 2,
  parameter logic [DATA_WID-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_read_enable,
  input  logic [63:0]         i_read_addr,
  input  logic                i_finish_read,
  input  logic                i_write_enable,
  input  logic [63:0]         i_write_addr,
  input  logic [DATA_WID-1:0] i_write_data,
  input  logic                i_finish_write,
  output logic [63:0]         o_read_ready,
  output logic [DATA_WID-1:0] o_read_data,
  output logic [63:0]         o_write_ready,
  output logic                o_busy,
  output logic [31:0]         o_oob_count
);

  localparam int DEPTH   = 2 ** ADDR_WID;
  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  // Room for the largest wait count plus up to 3 jitter cycles.
  localparam int CNT_W   = $clog2(MAX_LAT + 4);

  localparam logic [CNT_W-1:0] RD_CNT0  = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_CNT0  = CNT_W'(WR_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_RD_RESP = 3'd2,
    S_WR_WAIT = 3'd3,
    S_WR_RESP = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  // True when the byte address lands inside the backing RAM window.
  function automatic logic f_in_range(input logic [63:0] addr);
    return (addr >= BASE) && (((addr - BASE) >> (ADDR_WID + 2)) == 64'd0);
  endfunction

  // Word index inside the RAM; the two byte-offset bits are ignored.
  function automatic logic [ADDR_WID-1:0] f_word_idx(input logic [63:0] addr);
    return ADDR_WID'((addr - BASE) >> 2);
  endfunction

  logic [DATA_WID-1:0] r_mem [DEPTH];

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [63:0]         r_addr;
  logic [DATA_WID-1:0] r_data;
  logic                r_pend;
  logic [63:0]         r_pend_addr;
  logic [DATA_WID-1:0] r_pend_data;
  logic [31:0]         r_fin_rd_cnt;
  logic [31:0]         r_fin_wr_cnt;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [63:0]         w_addr_nxt;
  logic [DATA_WID-1:0] w_data_nxt;
  logic                w_pend_nxt;
  logic [63:0]         w_pend_addr_nxt;
  logic [DATA_WID-1:0] w_pend_data_nxt;
  logic [CNT_W-1:0]    w_jit;
  logic                w_oob_hit;
  logic                w_fin_unused;

`ifdef RESP_JITTER_EN
  logic [15:0] r_lfsr;
  logic        w_accept;

  assign w_accept = (r_state == S_IDLE) && (i_read_enable || r_pend || i_write_enable);
  assign w_jit    = {{(CNT_W-2){1'b0}}, r_lfsr[1:0]};

  // Jitter LFSR: x^16+x^14+x^13+x^11, steps once per accepted access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= 16'hACE1;
    end else if (w_accept) begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end
`else
  assign w_jit = CNT_ZERO;
`endif

  // Next-state logic: IDLE arbitration (read, then pending write, then new write) and wait countdown.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_addr_nxt      = r_addr;
    w_data_nxt      = r_data;
    w_pend_nxt      = r_pend;
    w_pend_addr_nxt = r_pend_addr;
    w_pend_data_nxt = r_pend_data;
    case (r_state)
      S_IDLE: begin
        if (i_read_enable) begin
          w_state_nxt = S_RD_WAIT;
          w_cnt_nxt   = RD_CNT0 + w_jit;
          w_addr_nxt  = i_read_addr;
          // A write arriving with the read is parked, unless the slot is already taken.
          if (i_write_enable && !r_pend) begin
            w_pend_nxt      = 1'b1;
            w_pend_addr_nxt = i_write_addr;
            w_pend_data_nxt = i_write_data;
          end else begin
            w_pend_nxt = r_pend;
          end
        end else if (r_pend) begin
          w_state_nxt = S_WR_WAIT;
          w_cnt_nxt   = WR_CNT0 + w_jit;
          w_addr_nxt  = r_pend_addr;
          w_data_nxt  = r_pend_data;
          w_pend_nxt  = 1'b0;
        end else if (i_write_enable) begin
          w_state_nxt = S_WR_WAIT;
          w_cnt_nxt   = WR_CNT0 + w_jit;
          w_addr_nxt  = i_write_addr;
          w_data_nxt  = i_write_data;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        if (r_cnt == CNT_ZERO) begin
          w_state_nxt = S_RD_RESP;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      S_WR_WAIT: begin
        if (r_cnt == CNT_ZERO) begin
          w_state_nxt = S_WR_RESP;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      S_RD_RESP: w_state_nxt = S_HOLD;
      S_WR_RESP: w_state_nxt = S_HOLD;
      // One dead cycle so a streaming initiator can move its address before we sample again.
      S_HOLD:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  assign w_oob_hit = ((r_state == S_RD_RESP) || (r_state == S_WR_RESP)) && !f_in_range(r_addr);

  // Control state and registered outputs; ready rises on the edge that leaves a RESP state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= CNT_ZERO;
      r_addr        <= 64'd0;
      r_data        <= {DATA_WID{1'b0}};
      r_pend        <= 1'b0;
      r_pend_addr   <= 64'd0;
      r_pend_data   <= {DATA_WID{1'b0}};
      o_read_ready  <= 64'd0;
      o_read_data   <= {DATA_WID{1'b0}};
      o_write_ready <= 64'd0;
      o_busy        <= 1'b0;
      o_oob_count   <= 32'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_addr        <= w_addr_nxt;
      r_data        <= w_data_nxt;
      r_pend        <= w_pend_nxt;
      r_pend_addr   <= w_pend_addr_nxt;
      r_pend_data   <= w_pend_data_nxt;
      o_read_ready  <= (r_state == S_RD_RESP) ? 64'd1 : 64'd0;
      o_write_ready <= (r_state == S_WR_RESP) ? 64'd1 : 64'd0;
      o_busy        <= (w_state_nxt != S_IDLE) || w_pend_nxt;
      if (r_state == S_RD_RESP) begin
        o_read_data <= f_in_range(r_addr) ? r_mem[f_word_idx(r_addr)] : ERR_DATA;
      end
      if (w_oob_hit && (o_oob_count != 32'hFFFF_FFFF)) begin
        o_oob_count <= o_oob_count + 32'd1;
      end
    end
  end

  // Backing RAM: no reset, writes commit in WR_RESP, out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if ((r_state == S_WR_RESP) && f_in_range(r_addr)) begin
      r_mem[f_word_idx(r_addr)] <= r_data;
    end
  end

  // Stream-ack bookkeeping; the acks never steer the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fin_rd_cnt <= 32'd0;
      r_fin_wr_cnt <= 32'd0;
    end else begin
      r_fin_rd_cnt <= r_fin_rd_cnt + {31'd0, i_finish_read};
      r_fin_wr_cnt <= r_fin_wr_cnt + {31'd0, i_finish_write};
    end
  end

  assign w_fin_unused = ^{r_fin_rd_cnt, r_fin_wr_cnt};

endmodule
